// File: rtl/tick_stream_arbiter_if.sv
// rtl/tick_stream_arbiter_if.sv - producer/consumer stream bundle around the tick stream arbiter
// slave is the arbiter's view; master is the surrounding producers plus the consumer.
interface tick_stream_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int IDW   = 2
);
  logic [N*WIDTH-1:0] input_data;
  logic [N-1:0]       input_stb;
  logic [N-1:0]       input_ack;
  logic [WIDTH-1:0]   output_data;
  logic [IDW-1:0]     output_id;
  logic               output_stb;
  logic               output_ack;

  modport slave (
    input  input_data,
    input  input_stb,
    input  output_ack,
    output input_ack,
    output output_data,
    output output_id,
    output output_stb
  );

  modport master (
    output input_data,
    output input_stb,
    output output_ack,
    input  input_ack,
    input  output_data,
    input  output_id,
    input  output_stb
  );
endinterface

// File: rtl/tick_stream_arbiter.sv
// rtl/tick_stream_arbiter.sv - round-robin merge of N stb/ack producers onto one tagged stream
// One word is captured per grant and held until the consumer acks it.
module tick_stream_arbiter #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  tick_stream_arbiter_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);
  localparam logic [IDW:0]   N_EXT    = (IDW + 1)'(N);

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_last_grant, w_last_grant_nxt;
  logic [WIDTH-1:0] r_out_data, w_out_data_nxt;
  logic [IDW-1:0]   r_out_id, w_out_id_nxt;
  logic             r_out_stb, w_out_stb_nxt;
  logic [N-1:0]     r_in_ack, w_in_ack_nxt;

  logic             w_found;
  logic [IDW-1:0]   w_sel;
  logic [WIDTH-1:0] w_sel_data;

  // Search starts one past the last grant so every requester gets a turn within N grants.
  always_comb begin : rr_search
    logic [IDW:0] v_sum;
    w_found = 1'b0;
    w_sel   = '0;
    v_sum   = '0;
    for (int k = 1; k <= N; k++) begin
      v_sum = {1'b0, r_last_grant} + (IDW + 1)'(k);
      if (v_sum >= N_EXT) begin
        v_sum = v_sum - N_EXT;
      end
      if (!w_found && bus.input_stb[v_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = v_sum[IDW-1:0];
      end
    end
  end

  always_comb begin : data_mux
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_sel == IDW'(i)) begin
        w_sel_data = bus.input_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : fsm_next
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_out_data_nxt   = r_out_data;
    w_out_id_nxt     = r_out_id;
    w_out_stb_nxt    = r_out_stb;
    w_in_ack_nxt     = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_out_data_nxt   = w_sel_data;
          w_out_id_nxt     = w_sel;
          w_out_stb_nxt    = 1'b1;
          w_in_ack_nxt     = N'(1) << w_sel;
          w_last_grant_nxt = w_sel;
          w_state_nxt      = SEND;
        end
      end
      SEND: begin
        if (r_out_stb && bus.output_ack) begin
          w_out_stb_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= LAST_RST;
      r_out_data   <= '0;
      r_out_id     <= '0;
      r_out_stb    <= 1'b0;
      r_in_ack     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_id     <= w_out_id_nxt;
      r_out_stb    <= w_out_stb_nxt;
      r_in_ack     <= w_in_ack_nxt;
    end
  end

  assign bus.output_data = r_out_data;
  assign bus.output_id   = r_out_id;
  assign bus.output_stb  = r_out_stb;
  assign bus.input_ack   = r_in_ack;

endmodule

// File: tb/tb_tick_stream_arbiter.sv
// tb/tb_tick_stream_arbiter.sv - scoreboard bench for tick_stream_arbiter
// Sources and consumer are driven on the falling edge; a monitor compares just after it.
module tb_tick_stream_arbiter;
  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tick_stream_arbiter_if #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) bus ();

  tick_stream_arbiter #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] cur [N];
  int               left [N];
  int               wait_cnt [N];
  logic [N-1:0]     req      = '0;
  logic [N-1:0]     pend_ack = '0;
  logic [N-1:0]     ack_exp  = '0;
  logic [N-1:0]     prev_stb = '0;
  bit               stb_exp  = 1'b0;
  bit               busy     = 1'b0;
  int               last_g   = N - 1;
  int               ack_pct  = 100;
  int               req_pct  = 100;
  logic [IDW+WIDTH-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One falling-edge step: source behaviour, consumer behaviour, then the
  // reference prediction of what the next rising edge does.
  task automatic cycle(input bit rst_val);
    @(negedge clk);
    rst = rst_val;
    if (!rst_val) begin
      busy     = 1'b0;
      last_g   = N - 1;
      exp_q.delete();
      pend_ack = '0;
      ack_exp  = '0;
      stb_exp  = 1'b0;
    end else begin
      ack_exp  = pend_ack;
      pend_ack = '0;
      stb_exp  = busy;
      for (int i = 0; i < N; i++) begin
        if (ack_exp[i]) begin
          req[i] = 1'b0;
          cur[i] = WIDTH'($urandom);
          if (left[i] > 0) left[i]--;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!req[i] && left[i] > 0 && $urandom_range(99) < req_pct) req[i] = 1'b1;
    end
    bus.input_stb = req;
    for (int i = 0; i < N; i++) bus.input_data[i*WIDTH +: WIDTH] = cur[i];
    bus.output_ack = ($urandom_range(99) < ack_pct);
    if (rst_val) begin
      if (busy && bus.output_ack) begin
        busy = 1'b0;
      end else if (!busy && req != '0) begin
        int w;
        w = -1;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (last_g + k) % N;
          if (w < 0 && req[c]) w = c;
        end
        exp_q.push_back({IDW'(w), cur[w]});
        pend_ack[w] = 1'b1;
        last_g      = w;
        busy        = 1'b1;
      end
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    chk("input_ack", 32'(bus.input_ack), 32'(ack_exp));
    chk("output_stb", 32'(bus.output_stb), 32'(stb_exp));
    if (!rst) begin
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else if (bus.input_ack != '0) begin
      for (int i = 0; i < N; i++) begin
        if (bus.input_ack[i]) begin
          chk("fair_wait", 32'(wait_cnt[i] <= N - 1), 32'd1);
          wait_cnt[i] = 0;
        end else if (prev_stb[i]) begin
          wait_cnt[i]++;
        end
      end
    end
    if (stb_exp) begin
      if (exp_q.size() == 0) begin
        chk("exp_avail", 32'd0, 32'd1);
      end else begin
        chk("output_data", 32'(bus.output_data), 32'(exp_q[0][WIDTH-1:0]));
        chk("output_id", 32'(bus.output_id), 32'(exp_q[0][IDW+WIDTH-1:WIDTH]));
        if (bus.output_ack) void'(exp_q.pop_front());
      end
    end
    prev_stb = bus.input_stb;
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      cur[i]      = '0;
      left[i]     = 0;
      wait_cnt[i] = 0;
    end
    bus.input_stb  = '0;
    bus.input_data = '0;
    bus.output_ack = 1'b0;

    repeat (3) cycle(1'b0);
    #2;
    chk("rst_output_data", 32'(bus.output_data), 32'd0);
    chk("rst_output_id", 32'(bus.output_id), 32'd0);

    // single word from source 0
    cur[0]  = 16'h1234;
    left[0] = 1;
    repeat (6) cycle(1'b1);

    // all sources requesting, consumer always ready
    for (int i = 0; i < N; i++) left[i] = 3;
    repeat (30) cycle(1'b1);

    // consumer stalls while source 2's word is pending; source 3 must wait
    ack_pct = 0;
    left[2] = 1;
    cycle(1'b1);
    left[3] = 1;
    repeat (10) cycle(1'b1);
    ack_pct = 100;
    repeat (8) cycle(1'b1);

    // pointer at 3, sources 1 and 3 requesting: wrap to 1
    left[1] = 1;
    left[3] = 1;
    repeat (8) cycle(1'b1);

    // reset in the middle of SEND
    ack_pct = 0;
    left[3] = 1;
    repeat (3) cycle(1'b1);
    cycle(1'b0);
    left[2] = 1;
    left[3] = 1;
    cycle(1'b0);
    ack_pct = 100;
    repeat (8) cycle(1'b1);

    // random traffic
    req_pct = 30;
    ack_pct = 70;
    for (int i = 0; i < N; i++) left[i] = 100000;
    repeat (10000) cycle(1'b1);

    // drain: every captured word must reach the consumer
    for (int i = 0; i < N; i++) left[i] = 0;
    ack_pct = 100;
    repeat (40) cycle(1'b1);
    #2;
    chk("drain_exp_q", 32'(exp_q.size()), 32'd0);
    chk("drain_req", 32'(req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
